// File: rtl/dec_3_8_hold_v_pkg.sv
// Shared definitions for the sequential 3-to-8 decoder: FSM encodings, FIFO entry
// layout and the one-hot decode used by both the RTL and pattern checks.
package dec_3_8_hold_v_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int ENTRY_W = 4;
    localparam int CNT_W   = 8;

    typedef struct packed {
        logic       none;
        logic [2:0] code;
    } entry_t;

    // A "none" entry decodes to all-zero but is still replayed like a real code.
    function automatic logic [7:0] decode_onehot(input entry_t e);
        logic [7:0] pat;
        case (e.code)
            3'd0:    pat = 8'h01;
            3'd1:    pat = 8'h02;
            3'd2:    pat = 8'h04;
            3'd3:    pat = 8'h08;
            3'd4:    pat = 8'h10;
            3'd5:    pat = 8'h20;
            3'd6:    pat = 8'h40;
            3'd7:    pat = 8'h80;
            default: pat = 8'h00;
        endcase
        return e.none ? 8'h00 : pat;
    endfunction

endpackage

// File: rtl/dec_3_8_hold_v_fifo.sv
// Small synchronous FIFO with show-ahead read data; pushes when full and pops when
// empty are ignored so the stored order can never be corrupted.
module sync_fifo_v #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign rd_data   = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array; only the slot under the write pointer changes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Occupancy; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/dec_3_8_hold_v.sv
// Sequential 3-to-8 decoder: queues {none, code} entries and replays each as a
// one-hot pattern held HOLD_CYCLES, followed by GAP_CYCLES of all-zero output.
module dec_3_8_hold_v
    import dec_3_8_hold_v_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int DEPTH       = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_code,
    input  logic       i_none,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [7:0] o_code,
    output logic       o_strobe,
    output logic       o_busy
);

    localparam int               CW     = $clog2(DEPTH) + 1;
    localparam bit               GAP_EN = (GAP_CYCLES > 0);
    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_M1  = GAP_EN ? CNT_W'(GAP_CYCLES - 1) : {CNT_W{1'b0}};

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || GAP_CYCLES < 0 || GAP_CYCLES > 255 ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_cfg_err
        $error("dec_3_8_hold_v: illegal HOLD_CYCLES/GAP_CYCLES/DEPTH configuration");
    end

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic [7:0]         code_r;
    logic [7:0]         code_s;
    logic               strobe_r;
    logic               strobe_s;
    logic               load_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CW-1:0]      fifo_count_s;
    logic [ENTRY_W-1:0] fifo_rd_s;
    entry_t             head_s;

    assign head_s   = fifo_rd_s;
    assign o_ready  = !fifo_full_s;
    assign o_busy   = (state_r != ST_IDLE) || (fifo_count_s != {CW{1'b0}});
    assign o_code   = code_r;
    assign o_strobe = strobe_r;

    sync_fifo_v #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (i_valid && o_ready),
        .wr_data ({i_none, i_code}),
        .pop     (load_s),
        .rd_data (fifo_rd_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Next-state, counter and output pattern; a load pops the FIFO head.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        code_s   = code_r;
        strobe_s = 1'b0;
        load_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                code_s = 8'h00;
                if (!fifo_empty_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_HOLD: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_s = cnt_r - CNT_W'(1);
                end else if (GAP_EN) begin
                    code_s  = 8'h00;
                    cnt_s   = GAP_M1;
                    state_s = ST_GAP;
                end else if (!fifo_empty_s) begin
                    load_s = 1'b1;
                end else begin
                    code_s  = 8'h00;
                    state_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                code_s = 8'h00;
                if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_s = cnt_r - CNT_W'(1);
                end else if (!fifo_empty_s) begin
                    load_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
                code_s  = 8'h00;
            end
        endcase

        if (load_s) begin
            code_s   = decode_onehot(head_s);
            strobe_s = 1'b1;
            cnt_s    = HOLD_M1;
            state_s  = ST_HOLD;
        end else begin
            strobe_s = 1'b0;
        end
    end

    // State and output registers; reset drops any pattern in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            code_r   <= 8'h00;
            strobe_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            code_r   <= code_s;
            strobe_r <= strobe_s;
        end
    end

endmodule

// File: tb/tb_dec_3_8_hold_v.sv
// Bench for dec_3_8_hold_v: three differently configured lanes, a queue-based
// scoreboard fed by the stimulus and a monitor that checks every cycle.
module tb_dec_3_8_hold_v;

    localparam int NL    = 3;
    localparam int DEPTH = 4;

    function automatic int hold_of(input int k);
        case (k)
            0:       return 4;
            1:       return 2;
            default: return 10;
        endcase
    endfunction

    function automatic int gap_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 2;
        endcase
    endfunction

    typedef struct {
        logic [7:0] pat;
        int         push_edge;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] t_code  [NL];
    logic       t_none  [NL];
    logic       t_valid [NL];
    logic       ready   [NL];
    logic       strobe  [NL];
    logic       busy    [NL];
    logic [7:0] dcode   [NL];

    exp_t sbq [NL][$];
    int   errors   = 0;
    int   checks   = 0;
    int   edge_cnt = 0;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        dec_3_8_hold_v #(
            .HOLD_CYCLES (hold_of(g)),
            .GAP_CYCLES  (gap_of(g)),
            .DEPTH       (DEPTH)
        ) dut (
            .i_clk    (clk),
            .i_rst_n  (rst_n),
            .i_code   (t_code[g]),
            .i_none   (t_none[g]),
            .i_valid  (t_valid[g]),
            .o_ready  (ready[g]),
            .o_code   (dcode[g]),
            .o_strobe (strobe[g]),
            .o_busy   (busy[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
        end
    end

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d: got %0h expected %0h (edge %0d)", name, k, act, exp, edge_cnt);
        end
    endtask

    // One cycle of stimulus, starting just after a rising edge. Accepted entries are
    // scored with the edge on which the handshake happens.
    task automatic step(input logic [NL-1:0] v, input logic [NL-1:0] n,
                        input logic [3*NL-1:0] c, output logic [NL-1:0] acc);
        exp_t e;
        for (int k = 0; k < NL; k++) begin
            t_valid[k] = v[k];
            t_none[k]  = n[k];
            t_code[k]  = c[3*k +: 3];
        end
        for (int k = 0; k < NL; k++) begin
            acc[k] = v[k] && ready[k];
            if (acc[k]) begin
                e.pat       = n[k] ? 8'h00 : 8'(1 << c[3*k +: 3]);
                e.push_edge = edge_cnt + 1;
                sbq[k].push_back(e);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NL; k++) begin
            t_valid[k] = 1'b0;
        end
    endtask

    task automatic idle(input int cycles);
        logic [NL-1:0] acc;
        for (int i = 0; i < cycles; i++) begin
            step('0, '0, '0, acc);
        end
    endtask

    task automatic send(input int k, input logic none, input logic [2:0] code);
        logic [NL-1:0]   acc;
        logic [NL-1:0]   v;
        logic [NL-1:0]   n;
        logic [3*NL-1:0] c;
        v = '0;
        n = '0;
        c = '0;
        v[k] = 1'b1;
        n[k] = none;
        c[3*k +: 3] = code;
        for (int t = 0; t < 300; t++) begin
            step(v, n, c, acc);
            if (acc[k]) return;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout lane%0d: got no acceptance expected one within 300 cycles", k);
    endtask

    // Monitor: expected load edge of an entry is max(push edge + 1, previous load +
    // hold + gap); output is the pattern for hold cycles after a load, zero otherwise.
    initial begin : monitor
        int         last_s  [NL];
        bit         have_s  [NL];
        logic [7:0] cur_pat [NL];
        int         h;
        int         p;
        int         ld;
        int         occ;
        bit         due;
        logic [7:0] ec;
        bit         eb;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NL; k++) begin
                if (!rst_n) begin
                    have_s[k]  = 1'b0;
                    last_s[k]  = 0;
                    cur_pat[k] = 8'h00;
                end else begin
                    h   = hold_of(k);
                    p   = h + gap_of(k);
                    due = 1'b0;
                    if (sbq[k].size() > 0) begin
                        ld = sbq[k][0].push_edge + 1;
                        if (have_s[k] && (last_s[k] + p > ld)) ld = last_s[k] + p;
                        due = (ld == edge_cnt);
                    end
                    check("strobe", k, 32'(strobe[k]), 32'(due));
                    if (due) begin
                        cur_pat[k] = sbq[k][0].pat;
                        void'(sbq[k].pop_front());
                        last_s[k] = edge_cnt;
                        have_s[k] = 1'b1;
                    end
                    ec = (have_s[k] && edge_cnt < last_s[k] + h) ? cur_pat[k] : 8'h00;
                    check("code", k, 32'(dcode[k]), 32'(ec));
                    occ = 0;
                    for (int i = 0; i < sbq[k].size(); i++) begin
                        if (sbq[k][i].push_edge <= edge_cnt) occ++;
                    end
                    check("ready", k, 32'(ready[k]), 32'(occ < DEPTH));
                    eb = (occ > 0) || (have_s[k] && edge_cnt < last_s[k] + p);
                    check("busy", k, 32'(busy[k]), 32'(eb));
                end
            end
        end
    end

    initial begin : stim
        logic [NL-1:0]   v;
        logic [NL-1:0]   n;
        logic [3*NL-1:0] c;
        logic [NL-1:0]   acc;
        rst_n = 1'b0;
        for (int k = 0; k < NL; k++) begin
            t_valid[k] = 1'b0;
            t_none[k]  = 1'b0;
            t_code[k]  = 3'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NL; k++) begin
            check("rst_code", k, 32'(dcode[k]), 32'h0);
            check("rst_strobe", k, 32'(strobe[k]), 32'h0);
            check("rst_busy", k, 32'(busy[k]), 32'h0);
            check("rst_ready", k, 32'(ready[k]), 32'h1);
        end
        rst_n = 1'b1;

        // Single code on the HOLD=4/GAP=1 lane, then 7, none, 1 queued together.
        send(0, 1'b0, 3'd3);
        idle(10);
        send(0, 1'b0, 3'd7);
        send(0, 1'b1, 3'd0);
        send(0, 1'b0, 3'd1);
        idle(20);

        // Back-to-back walk on the HOLD=2/GAP=0 lane.
        for (int i = 0; i < 8; i++) begin
            send(1, 1'b0, 3'(i));
        end
        idle(20);

        // Overfill the slow HOLD=10 lane: the sixth entry must wait for a pop.
        for (int i = 1; i <= 6; i++) begin
            send(2, 1'b0, 3'(i));
        end
        idle(80);

        // Asynchronous reset mid-HOLD with three entries still queued.
        send(0, 1'b0, 3'd5);
        send(0, 1'b0, 3'd6);
        send(0, 1'b0, 3'd2);
        send(0, 1'b0, 3'd4);
        #2;
        rst_n = 1'b0;
        for (int k = 0; k < NL; k++) begin
            sbq[k].delete();
        end
        #1;
        for (int k = 0; k < NL; k++) begin
            check("async_rst_code", k, 32'(dcode[k]), 32'h0);
            check("async_rst_busy", k, 32'(busy[k]), 32'h0);
            check("async_rst_ready", k, 32'(ready[k]), 32'h1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic on all lanes at different offered loads.
        for (int i = 0; i < 1500; i++) begin
            v[0] = ($urandom_range(0, 2) == 0);
            v[1] = ($urandom_range(0, 1) == 0);
            v[2] = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NL; k++) begin
                n[k] = ($urandom_range(0, 7) == 0);
            end
            c = 9'($urandom);
            step(v, n, c, acc);
        end
        idle(200);

        for (int k = 0; k < NL; k++) begin
            check("drained", k, 32'(sbq[k].size()), 32'h0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
